pitch_estimator: RTL

//  Upstream stage of the pitch PID: turns raw gyro pitch-rate and accel samples into the

---
 rtl/inertial_pkg.sv | 31 +++
 rtl/rate_offset_cal.sv | 35 +++
 rtl/pitch_estimator.sv | 113 +++++++++++
 3 files changed

// File: rtl/inertial_pkg.sv
// Shared types, widths and saturation helpers for the pitch estimation path.
package inertial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } est_state_t;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned PTCH_INT_W = 27;
  localparam int unsigned CAL_SUM_W  = 24;
  localparam logic signed [15:0] AZ_SCALE = 16'sd327;

  // Clamp a 17b signed difference into 16b
  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    logic signed [15:0] r;
    if (x[16] != x[15]) r = x[16] ? 16'sh8000 : 16'sh7FFF;
    else                r = x[15:0];
    return r;
  endfunction

  // Clamp a 29b signed sum of three 27b terms into 27b
  function automatic logic signed [26:0] sat27(input logic signed [28:0] x);
    logic signed [26:0] r;
    if (x[28:26] != {3{x[28]}}) r = x[28] ? {1'b1, 26'd0} : {1'b0, {26{1'b1}}};
    else                        r = x[26:0];
    return r;
  endfunction

endpackage

// File: rtl/rate_offset_cal.sv
// Gyro offset learner: averages 2^CAL_LOG2 raw rate samples after each start.
module rate_offset_cal
  import inertial_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sample,
  input  logic signed [15:0] raw,
  output logic               done_c,
  output logic signed [15:0] offset_c
);

  logic signed [CAL_SUM_W-1:0] sum;
  logic signed [CAL_SUM_W-1:0] sum_nxt;
  logic        [CAL_LOG2-1:0]  cnt;

  assign sum_nxt  = sum + {{(CAL_SUM_W - DATA_W){raw[15]}}, raw};
  // A start in the same cycle as the last sample restarts instead of finishing
  assign done_c   = sample && !start && (cnt == '1);
  assign offset_c = 16'(sum_nxt >>> CAL_LOG2);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      sum <= '0;
      cnt <= '0;
    end else if (sample) begin
      sum <= sum_nxt;
      cnt <= cnt + CAL_LOG2'(1);
    end
  end

endmodule

// File: rtl/pitch_estimator.sv
// Pitch estimator: gyro offset calibration, rate integration and accel drift fusion.
module pitch_estimator
  import inertial_pkg::*;
#(
  parameter bit          fast_sim   = 1'b1,
  parameter logic [15:0] AZ_OFFSET  = 16'h00A0,
  parameter logic [26:0] FUSION_INC = 27'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld_in,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  input  logic               cal_req,
  input  logic               rider_off,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               vld,
  output logic               cal_done
);

  localparam int unsigned CAL_LOG2 = fast_sim ? 4 : 8;
  localparam logic signed [PTCH_INT_W-1:0] FUSE_POS = FUSION_INC;
  localparam logic signed [PTCH_INT_W-1:0] FUSE_NEG = -FUSION_INC;

  est_state_t                   state;
  logic signed [15:0]           offset;
  logic signed [PTCH_INT_W-1:0] ptch_int;

  logic                         cal_sample;
  logic                         cal_done_c;
  logic signed [15:0]           cal_offset_c;
  logic signed [16:0]           corr_wide;
  logic signed [15:0]           corr;
  logic signed [15:0]           az_s;
  logic signed [25:0]           acc_prod;
  logic signed [15:0]           ptch_acc;
  logic signed [PTCH_INT_W-1:0] fuse;
  logic signed [PTCH_INT_W+1:0] int_sum;
  logic signed [PTCH_INT_W-1:0] ptch_int_nxt;

  assign cal_sample = vld_in && (state == CAL);

  rate_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal (
    .clk      (clk),
    .rst      (rst),
    .start    (cal_req),
    .sample   (cal_sample),
    .raw      (ptch_rt_raw),
    .done_c   (cal_done_c),
    .offset_c (cal_offset_c)
  );

  // Offset-corrected rate and accel-derived pitch for the current sample
  assign corr_wide = {ptch_rt_raw[15], ptch_rt_raw} - {offset[15], offset};
  assign corr      = sat16(corr_wide);
  assign az_s      = AZ - AZ_OFFSET;
  assign acc_prod  = 26'(az_s) * 26'(AZ_SCALE);
  assign ptch_acc  = 16'(acc_prod >>> 13);

  assign fuse = (ptch_acc > ptch) ? FUSE_POS :
                (ptch_acc < ptch) ? FUSE_NEG : '0;

  assign int_sum = {{2{ptch_int[PTCH_INT_W-1]}}, ptch_int}
                 + {{(PTCH_INT_W + 2 - DATA_W){corr[15]}}, corr}
                 + {{2{fuse[PTCH_INT_W-1]}}, fuse};
  assign ptch_int_nxt = sat27(int_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      offset   <= '0;
      ptch_int <= '0;
      ptch     <= '0;
      ptch_rt  <= '0;
      vld      <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        IDLE: begin
          if (cal_req) state <= CAL;
        end
        CAL: begin
          if (cal_done_c) begin
            state    <= RUN;
            offset   <= cal_offset_c;
            ptch_int <= '0;
            cal_done <= 1'b1;
          end
        end
        RUN: begin
          if (cal_req) begin
            state    <= CAL;
            cal_done <= 1'b0;
          end else if (vld_in) begin
            ptch_rt  <= corr;
            ptch_int <= ptch_int_nxt;
            ptch     <= ptch_int_nxt[PTCH_INT_W-1 -: DATA_W];
            vld      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Rider leaving overrides any integrator update in the same cycle
      if (rider_off) begin
        ptch_int <= '0;
        ptch     <= '0;
      end
    end
  end

endmodule
